// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for the shared instruction/data memory (CPU = port 0, loader = port 1).
// Optional macro ARB_ROUND_ROBIN_EN: rotating priority on simultaneous requests; default is fixed loader-first.
//
// state  | meaning
// IDLE   | no transaction; pick a winner when any req is high
// ACCESS | memory driven with the latched request for MEM_LAT cycles
// DONE   | one-cycle ack to the owner; memory strobes low
module mem_port_arbiter #(
  parameter int ADDR_W  = 13,
  parameter int DATA_W  = 8,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              ack0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              we_q;
  logic              owner_q;
  logic              any_req;
  logic              win;

  assign any_req = req0 | req1;

`ifdef ARB_ROUND_ROBIN_EN
  logic ptr;

  // ptr names the preferred port; it only matters when both ports ask at once
  always_comb begin
    win = req1;
    if (req0 && req1) win = ptr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= 1'b1;
    end else if (state == S_IDLE && any_req) begin
      ptr <= ~win;
    end
  end
`else
  assign win = req1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      owner_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            owner_q <= win;
            addr_q  <= win ? addr1 : addr0;
            wdata_q <= win ? wdata1 : wdata0;
            we_q    <= win ? we1 : we0;
            cnt     <= CNT_W'(MEM_LAT - 1);
            state   <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (cnt == '0) begin
            if (!we_q) rdata_q <= mem_rdata;
            state <= S_DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign gnt0      = busy & ~owner_q;
  assign gnt1      = busy & owner_q;
  assign ack0      = (state == S_DONE) & ~owner_q;
  assign ack1      = (state == S_DONE) & owner_q;
  assign mem_re    = (state == S_ACCESS) & ~we_q;
  assign mem_we    = (state == S_ACCESS) & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: per-port request drivers, a transaction-level reference model
// feeding a scoreboard, and a monitor that checks every cycle and every acknowledge.
module tb_mem_port_arbiter;

  localparam int AW  = 13;
  localparam int DW  = 8;
  localparam int LAT = 2;
  localparam int ACK_TMO = 200;

  logic          clk, rst;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, ack0, gnt1, ack1, mem_re, mem_we, busy;
  logic [DW-1:0] rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  // second instance with single-cycle memory latency
  logic          req0_b, we0_b;
  logic [AW-1:0] addr0_b, mem_addr_b;
  logic [DW-1:0] rdata_b, mem_wdata_b, mem_rdata_b;
  logic          gnt0_b, ack0_b, gnt1_b, ack1_b, mem_re_b, mem_we_b, busy_b;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .ack0(ack0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .ack1(ack1),
    .rdata(rdata), .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) dut_b (
    .clk(clk), .rst(rst),
    .req0(req0_b), .we0(we0_b), .addr0(addr0_b), .wdata0(8'h00), .gnt0(gnt0_b), .ack0(ack0_b),
    .req1(1'b0), .we1(1'b0), .addr1(13'h0000), .wdata1(8'h00), .gnt1(gnt1_b), .ack1(ack1_b),
    .rdata(rdata_b), .mem_re(mem_re_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; int gap; } op_t;
  typedef struct { int port; int ecyc; logic [DW-1:0] rdata; } exp_t;
  typedef struct { int port; int ecyc; } ack_t;

  op_t  op_q0[$], op_q1[$];
  exp_t sb[$];
  ack_t ack_log[$];

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic [DW-1:0] last_read;
  int            n_cmp, n_bad;
  int            ecount, last_n;
  bit            cur_valid, cur_we;
  int            cur_port, cur_n;
  logic [AW-1:0] cur_addr;
  logic [DW-1:0] cur_wdata;
  bit   [1:0]    drv_busy;
`ifdef ARB_ROUND_ROBIN_EN
  int            pref;
`endif

  assign mem_rdata   = mem[mem_addr];
  assign mem_rdata_b = mem_addr_b[7:0] ^ 8'h5A;

  initial forever begin
    @(posedge clk);
    if (mem_we) mem[mem_addr] = mem_wdata;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, ecount);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    cur_valid = 0;
    last_n    = -100;
    last_read = '0;
`ifdef ARB_ROUND_ROBIN_EN
    pref = 1;
`endif
  endtask

  // Reference: one transaction at a time, MEM_LAT+2 edges apart, winner chosen by the priority rule
  initial begin
    ecount = 0;
    model_reset();
    forever begin
      @(posedge clk);
      ecount++;
      if (!rst && ecount >= last_n + LAT + 2 && (req0 || req1)) begin
        int   p;
        exp_t e;
`ifdef ARB_ROUND_ROBIN_EN
        p    = (req0 && req1) ? pref : (req1 ? 1 : 0);
        pref = 1 - p;
`else
        p = req1 ? 1 : 0;
`endif
        cur_port  = p;
        cur_we    = (p == 1) ? we1 : we0;
        cur_addr  = (p == 1) ? addr1 : addr0;
        cur_wdata = (p == 1) ? wdata1 : wdata0;
        cur_n     = ecount;
        cur_valid = 1;
        last_n    = ecount;
        if (cur_we) ref_mem[cur_addr] = cur_wdata;
        else        last_read = ref_mem[cur_addr];
        e.port  = p;
        e.ecyc  = ecount + LAT;
        e.rdata = last_read;
        sb.push_back(e);
      end
    end
  end

  initial forever begin
    bit in_acc, in_done;
    @(negedge clk);
    in_acc  = cur_valid && ecount >= cur_n && ecount < cur_n + LAT;
    in_done = cur_valid && ecount == cur_n + LAT;
    chk("busy",   busy,   in_acc || in_done);
    chk("gnt0",   gnt0,   (in_acc || in_done) && cur_port == 0);
    chk("gnt1",   gnt1,   (in_acc || in_done) && cur_port == 1);
    chk("ack0",   ack0,   in_done && cur_port == 0);
    chk("ack1",   ack1,   in_done && cur_port == 1);
    chk("mem_re", mem_re, in_acc && !cur_we);
    chk("mem_we", mem_we, in_acc && cur_we);
    if (in_acc) chk("mem_addr", mem_addr, cur_addr);
    if (in_acc && cur_we) chk("mem_wdata", mem_wdata, cur_wdata);
    if (ack0 || ack1) begin
      ack_t a;
      a.port = ack1 ? 1 : 0;
      a.ecyc = ecount;
      ack_log.push_back(a);
      chk("ack_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("ack_port",  ack1,   e.port);
        chk("ack_cycle", ecount, e.ecyc);
        chk("rdata",     rdata,  e.rdata);
      end
    end else if (sb.size() != 0 && ecount > sb[0].ecyc) begin
      chk("ack_missing", ack0 | ack1, 1);
      void'(sb.pop_front());
    end
  end

  task automatic set_port(input int p, input logic r, input logic w,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p == 0) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
    else        begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
  endtask

  function automatic int front_gap(input int p);
    if (p == 0) return (op_q0.size() != 0) ? op_q0[0].gap : -1;
    return (op_q1.size() != 0) ? op_q1[0].gap : -1;
  endfunction

  function automatic logic get_ack(input int p);
    return (p == 0) ? ack0 : ack1;
  endfunction

  task automatic pop_op(input int p, output op_t o);
    if (p == 0) o = op_q0.pop_front();
    else        o = op_q1.pop_front();
  endtask

  // Requester: holds req and operands until ack; a gap-0 follow-up keeps req high through IDLE
  task automatic run_port(input int p);
    op_t o;
    int  t;
    forever begin
      @(negedge clk);
      if (front_gap(p) >= 0) begin
        drv_busy[p] = 1'b1;
        pop_op(p, o);
        repeat (o.gap) @(negedge clk);
        set_port(p, 1'b1, o.we, o.addr, o.wdata);
        forever begin
          t = 0;
          do begin @(negedge clk); t++; end while (!get_ack(p) && t < ACK_TMO);
          if (!get_ack(p)) chk($sformatf("ack_wait_p%0d", p), get_ack(p), 1);
          if (front_gap(p) == 0) begin
            pop_op(p, o);
            set_port(p, 1'b1, o.we, o.addr, o.wdata);
          end else break;
        end
        set_port(p, 1'b0, 1'b0, '0, '0);
        drv_busy[p] = 1'b0;
      end
    end
  endtask

  initial run_port(0);
  initial run_port(1);

  task automatic push_op(input int p, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input int gap);
    op_t o;
    o.we = w; o.addr = a; o.wdata = d; o.gap = gap;
    if (p == 0) op_q0.push_back(o);
    else        op_q1.push_back(o);
  endtask

  task automatic drain();
    int t = 0;
    while ((op_q0.size() != 0 || op_q1.size() != 0 || drv_busy != 2'b00) && t < 4000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 4000) chk("drain_timeout", drv_busy, 0);
    repeat (3) @(negedge clk);
    @(posedge clk);
  endtask

  initial begin
    int exp_order[4];
    int t, nb, nre, ackc;
    n_cmp = 0; n_bad = 0; drv_busy = 2'b00;
    rst = 1'b0;
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
    req0_b = 0; we0_b = 0; addr0_b = '0;
    for (int i = 0; i < (1 << AW); i++) begin
      logic [DW-1:0] v;
      v = DW'($urandom);
      mem[i] = v; ref_mem[i] = v;
    end
    mem[13'h0040] = 8'hA5; ref_mem[13'h0040] = 8'hA5;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_gnt",   {gnt0, gnt1, ack0, ack1}, 0);
    chk("rst_mem",   {mem_re, mem_we, busy}, 0);
    chk("rst_addr",  mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_rdata", rdata, 0);
    rst = 1'b0;
    @(posedge clk);

    push_op(0, 1'b0, 13'h0040, 8'h00, 0);
    drain();
    chk("t1_rdata", rdata, 8'hA5);

    push_op(1, 1'b1, 13'h1FFF, 8'h3C, 0);
    drain();
    chk("t2_rdata_after_write", rdata, 8'hA5);
    push_op(0, 1'b0, 13'h1FFF, 8'h00, 0);
    drain();
    chk("t2_rdata", rdata, 8'h3C);

    ack_log.delete();
    for (int i = 0; i < 4; i++) begin
      push_op(0, 1'b0, 13'(8'h20 + i), 8'h00, 0);
      push_op(1, 1'b0, 13'(8'h30 + i), 8'h00, 0);
    end
    drain();
`ifdef ARB_ROUND_ROBIN_EN
    exp_order = '{1, 0, 1, 0};
`else
    exp_order = '{1, 1, 1, 1};
`endif
    chk("t3_ack_count", ack_log.size(), 8);
    for (int i = 0; i < 4 && i < ack_log.size(); i++)
      chk($sformatf("t3_order%0d", i), ack_log[i].port, exp_order[i]);

    ack_log.delete();
    for (int i = 0; i < 3; i++) push_op(0, 1'b0, 13'(8'h10 + i), 8'h00, 0);
    drain();
    chk("t5_ack_count", ack_log.size(), 3);
    for (int i = 0; i + 1 < ack_log.size(); i++)
      chk($sformatf("t5_spacing%0d", i), ack_log[i+1].ecyc - ack_log[i].ecyc, LAT + 2);

    push_op(0, 1'b1, 13'h0123, 8'h77, 0);
    t = 0;
    while (!(mem_we && gnt0) && t < 50) begin @(negedge clk); t++; end
    chk("t4_in_write", mem_we, 1);
    @(negedge clk);
    #1 rst = 1'b1;
    model_reset();
    #1;
    chk("t4_mem_we",  mem_we, 0);
    chk("t4_gnt0",    gnt0, 0);
    chk("t4_busy",    busy, 0);
    chk("t4_ack0",    ack0, 0);
    chk("t4_rdata",   rdata, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    drain();

    for (int i = 0; i < 30; i++) begin
      for (int p = 0; p < 2; p++) begin
        logic [AW-1:0] a;
        a = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
        push_op(p, 1'($urandom_range(0, 1)), a, DW'($urandom), $urandom_range(0, 4));
      end
    end
    drain();
    chk("sb_empty", sb.size(), 0);

    nb = 0; nre = 0; ackc = 0;
    @(negedge clk);
    req0_b = 1'b1; we0_b = 1'b0; addr0_b = 13'h0155;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (busy_b) nb++;
      if (mem_re_b) nre++;
      if (ack0_b && ackc == 0) begin ackc = i; req0_b = 1'b0; end
    end
    chk("t6_ack_cycle", ackc, 2);
    chk("t6_busy_cycles", nb, 2);
    chk("t6_re_cycles", nre, 1);
    chk("t6_rdata", rdata_b, 8'h0F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared %0d mismatched %0d", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
